// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: bus-mapped switches, debounced buttons and N-digit 7-seg scan.
// Define MMIO_IO_CTRL_IRQ_EN for IRQMASK at 0x14 and a registered button irq.
module mmio_io_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          N_DIGITS   = 4,
  parameter int          SW_W       = 8,
  parameter int          BTN_W      = 4,
  parameter int          DEB_CYCLES = 250000,
  parameter int          SCAN_DIV   = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [31:0]         adr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [SW_W-1:0]     sw,
  input  logic [BTN_W-1:0]    btn,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                irq
);
  localparam int DW = 4 * N_DIGITS;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic              hit;
  logic              wr;
  logic [2:0]        sel;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic [BTN_W-1:0]  btn_s1, btn_s2;
  logic [BTN_W-1:0]  deb, deb_nxt, rise;
  logic [BTN_W-1:0]  edges, clr;
  logic [CW-1:0]     cnt [BTN_W];
  logic [DW-1:0]     disp;
  logic [N_DIGITS-1:0] blank;
  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [3:0]        nib;
  logic              unused;

  assign hit = (adr[31:5] == BASE_ADDR[31:5]);
  assign sel = adr[4:2];
  assign wr  = we & hit;
  assign clr = (wr && sel == 3'd2) ? wdata[BTN_W-1:0] : '0;
  assign nib = disp[{idx, 2'b00} +: 4];
  assign unused = ^{adr[1:0], wdata};

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // level flips only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    deb_nxt = deb;
    for (int k = 0; k < BTN_W; k++) begin
      if (btn_s2[k] != deb[k] && cnt[k] == CW'(DEB_CYCLES - 1))
        deb_nxt[k] = ~deb[k];
    end
  end

  assign rise = deb_nxt & ~deb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      deb    <= '0;
      for (int k = 0; k < BTN_W; k++) cnt[k] <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      deb    <= deb_nxt;
      for (int k = 0; k < BTN_W; k++) begin
        if (btn_s2[k] == deb[k] || deb_nxt[k] != deb[k])
          cnt[k] <= '0;
        else
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp  <= '0;
      blank <= '0;
      edges <= '0;
    end else begin
      if (wr && sel == 3'd3) disp  <= wdata[DW-1:0];
      if (wr && sel == 3'd4) blank <= wdata[N_DIGITS-1:0];
      edges <= (edges & ~clr) | rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      seg   <= 7'h7F;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (blank[idx]) begin
        an  <= '1;
        seg <= 7'h7F;
      end else begin
        an  <= ~(N_DIGITS'(1) << idx);
        seg <= hex7(nib);
      end
    end
  end

`ifdef MMIO_IO_CTRL_IRQ_EN
  logic [BTN_W-1:0] mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && sel == 3'd5) mask <= wdata[BTN_W-1:0];
      irq <= |(edges & mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        3'd0: rdata = 32'(sw_s2);
        3'd1: rdata = 32'(deb);
        3'd2: rdata = 32'(edges);
        3'd3: rdata = 32'(disp);
        3'd4: rdata = 32'(blank);
`ifdef MMIO_IO_CTRL_IRQ_EN
        3'd5: rdata = 32'(mask);
`endif
        default: rdata = '0;
      endcase
    end
  end
endmodule
